// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with blanking dead-time and a single-entry input buffer.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZB_EN.
module seg_decoder (
  input  logic [3:0] code_i,
  output logic [6:0] seg_o
);
  // Segment order {a,b,c,d,e,f,g}; codes A-F are dark.
  always_comb begin
    seg_o = 7'b0000000;
    case (code_i)
      4'h0: seg_o = 7'b1111110;
      4'h1: seg_o = 7'b0110000;
      4'h2: seg_o = 7'b1101101;
      4'h3: seg_o = 7'b1111001;
      4'h4: seg_o = 7'b0110011;
      4'h5: seg_o = 7'b1011011;
      4'h6: seg_o = 7'b1011111;
      4'h7: seg_o = 7'b1110000;
      4'h8: seg_o = 7'b1111111;
      4'h9: seg_o = 7'b1111011;
      default: seg_o = 7'b0000000;
    endcase
  end
endmodule

module seg_scan_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 1000,
  parameter int BLANK_CYC  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4*NUM_DIGITS-1:0] in_digits,
  input  logic [NUM_DIGITS-1:0]   in_dp,
  output logic [7:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);
  localparam int KW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [KW-1:0]           k_q, k_d;
  logic [4*NUM_DIGITS-1:0] actWord_q, actWord_d, pendWord_q, pendWord_d;
  logic [NUM_DIGITS-1:0]   actDp_q, actDp_d, pendDp_q, pendDp_d;
  logic                    pendFull_q, pendFull_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [7:0]              seg_q, seg_d;
  logic                    frameDone_q, frameDone_d;
  logic                    accept, transfer;
  logic [3:0]              curNibble;
  logic [6:0]              decSeg;
  logic [NUM_DIGITS-1:0]   lzb;

  assign in_ready   = !pendFull_q;
  assign an         = an_q;
  assign seg_out    = seg_q;
  assign frame_done = frameDone_q;

  // Slot sequencing: enable low forces IDLE with counters cleared.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    k_d     = k_q;
    if (!enable) begin
      state_d = IDLE;
      idx_d   = '0;
      k_d     = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = BLANK;
          idx_d   = '0;
          k_d     = '0;
        end
        BLANK: begin
          k_d = k_q + 1'b1;
          if (k_q == KW'(BLANK_CYC - 1)) state_d = SHOW;
        end
        SHOW: begin
          if (k_q == KW'(SCAN_DIV - 1)) begin
            k_d     = '0;
            state_d = BLANK;
            idx_d   = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A pending word moves to active at a frame boundary or when scanning restarts.
  always_comb begin
    accept     = in_valid && !pendFull_q;
    transfer   = pendFull_q && (frameDone_q || (state_q == IDLE && enable));
    pendWord_d = accept ? in_digits : pendWord_q;
    pendDp_d   = accept ? in_dp : pendDp_q;
    pendFull_d = accept ? 1'b1 : (transfer ? 1'b0 : pendFull_q);
    actWord_d  = transfer ? pendWord_q : actWord_q;
    actDp_d    = transfer ? pendDp_q : actDp_q;
  end

`ifdef SEG_SCAN_LZB_EN
  logic upperZero;
  always_comb begin
    lzb       = '0;
    upperZero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      upperZero = upperZero && (actWord_d[4*i +: 4] == 4'd0);
      lzb[i]    = upperZero;
    end
  end
`else
  assign lzb = '0;
`endif

  assign curNibble = actWord_d[{idx_d, 2'b00} +: 4];

  seg_decoder u_dec (
    .code_i (curNibble),
    .seg_o  (decSeg)
  );

  // Outputs are computed from next state so an/seg always match the current slot.
  always_comb begin
    an_d  = '1;
    seg_d = 8'd0;
    if (state_d == SHOW) begin
      an_d  = ~(NUM_DIGITS'(1) << idx_d);
      seg_d = {(lzb[idx_d] ? 7'd0 : decSeg), actDp_d[idx_d]};
    end
    frameDone_d = (state_d == SHOW) && (idx_d == IW'(NUM_DIGITS - 1)) &&
                  (k_d == KW'(SCAN_DIV - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      k_q         <= '0;
      actWord_q   <= '0;
      actDp_q     <= '0;
      pendWord_q  <= '0;
      pendDp_q    <= '0;
      pendFull_q  <= 1'b0;
      an_q        <= '1;
      seg_q       <= 8'd0;
      frameDone_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      k_q         <= k_d;
      actWord_q   <= actWord_d;
      actDp_q     <= actDp_d;
      pendWord_q  <= pendWord_d;
      pendDp_q    <= pendDp_d;
      pendFull_q  <= pendFull_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      frameDone_q <= frameDone_d;
    end
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYC=2.
// Expectations follow SEG_SCAN_LZB_EN when it is defined for the build.
module tb_seg_scan_ctrl;
  logic        clk;
  logic        rst;
  logic        enable;
  logic        inValid;
  logic        inReady;
  logic [15:0] inDigits;
  logic [3:0]  inDp;
  logic [7:0]  segOut;
  logic [3:0]  an;
  logic        frameDone;

  int nCompared;
  int nMismatched;

  typedef struct {
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [31:0] expSeg;
  } vec_t;

  vec_t vecs[5];

  seg_scan_ctrl #(.NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYC(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .in_valid   (inValid),
    .in_ready   (inReady),
    .in_digits  (inDigits),
    .in_dp      (inDp),
    .seg_out    (segOut),
    .an         (an),
    .frame_done (frameDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic waitFrameDone(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frameDone && n < 100);
    if (!frameDone) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL %s: frame_done not seen within %0d cycles", tag, n);
    end
  endtask

  // Starts at digit 0, slot k=2; walks the frame checking each digit's SHOW output.
  task automatic checkFrame(input string tag, input logic [31:0] expSeg);
    logic [3:0] expAn;
    for (int d = 0; d < 4; d++) begin
      if (d > 0) tick(8);
      expAn = ~(4'b0001 << d);
      checkOutput($sformatf("%s an d%0d", tag, d), 32'(an), 32'(expAn));
      checkOutput($sformatf("%s seg d%0d", tag, d), 32'(segOut), 32'(expSeg[8*d +: 8]));
    end
  endtask

  task automatic applyStimulus(input logic [15:0] digits, input logic [3:0] dp);
    checkOutput("readyBeforeWrite", 32'(inReady), 32'd1);
    inValid  = 1'b1;
    inDigits = digits;
    inDp     = dp;
    tick(1);
    inValid  = 1'b0;
  endtask

  initial begin
    int n;
    int pulses;
    nCompared   = 0;
    nMismatched = 0;
    rst      = 1'b1;
    enable   = 1'b0;
    inValid  = 1'b0;
    inDigits = 16'h0000;
    inDp     = 4'b0000;

    vecs[0] = '{16'h00A5, 4'b1100,
`ifdef SEG_SCAN_LZB_EN
                32'h010100B6};
`else
                32'hFDFD00B6};
`endif
    vecs[1] = '{16'h9876, 4'b0000, 32'hF6FEE0BE};
    vecs[2] = '{16'h0042, 4'b0000,
`ifdef SEG_SCAN_LZB_EN
                32'h000066DA};
`else
                32'hFCFC66DA};
`endif
    vecs[3] = '{16'h0000, 4'b0001,
`ifdef SEG_SCAN_LZB_EN
                32'h000000FD};
`else
                32'hFCFCFCFD};
`endif
    vecs[4] = '{16'hFBC3, 4'b1010, 32'h010001F2};

    tick(2);
    checkOutput("rstAn", 32'(an), 32'hF);
    checkOutput("rstSeg", 32'(segOut), 32'h0);
    checkOutput("rstReady", 32'(inReady), 32'd1);
    checkOutput("rstFrameDone", 32'(frameDone), 32'd0);
    rst = 1'b0;
    tick(2);
    checkOutput("idleAn", 32'(an), 32'hF);

    // First slot timing after enabling.
    enable = 1'b1;
    tick(1);
    checkOutput("k0An", 32'(an), 32'hF);
    checkOutput("k0Seg", 32'(segOut), 32'h0);
    tick(1);
    checkOutput("k1An", 32'(an), 32'hF);
    tick(1);
    checkOutput("k2An", 32'(an), 32'hE);
    checkOutput("k2Seg", 32'(segOut), 32'hFC);
    tick(5);
    checkOutput("k7An", 32'(an), 32'hE);
    tick(1);
    checkOutput("d1k0An", 32'(an), 32'hF);
    checkOutput("d1k0Seg", 32'(segOut), 32'h0);
    tick(2);
    checkOutput("d1k2An", 32'(an), 32'hD);

    // Mid-frame write, then a second write while pending is full.
    applyStimulus(16'h1234, 4'b0000);
    checkOutput("readyLowAfterAccept", 32'(inReady), 32'd0);
    checkOutput("displayUnchangedAn", 32'(an), 32'hD);
    checkOutput("displayUnchangedSeg", 32'(segOut), 32'hFC);
    inValid  = 1'b1;
    inDigits = 16'h5678;
    tick(1);
    inValid  = 1'b0;
    checkOutput("readyLowWhileFull", 32'(inReady), 32'd0);
    waitFrameDone("w1234");
    checkOutput("readyLowAtFrameDone", 32'(inReady), 32'd0);
    tick(1);
    checkOutput("readyHighAfterFrame", 32'(inReady), 32'd1);
    checkOutput("blankAfterFrame", 32'(an), 32'hF);
    tick(2);
    checkFrame("w1234", 32'h60DAF266);
    waitFrameDone("w1234b");
    tick(3);
    checkFrame("w1234kept", 32'h60DAF266);

    // Frame period and pulse width.
    waitFrameDone("period");
    tick(1);
    checkOutput("frameDonePulse", 32'(frameDone), 32'd0);
    n = 1;
    while (!frameDone && n < 100) begin
      tick(1);
      n++;
    end
    checkOutput("framePeriod", 32'(n), 32'd32);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].digits, vecs[i].dp);
      waitFrameDone($sformatf("vec%0d", i));
      tick(3);
      checkFrame($sformatf("vec%0d", i), vecs[i].expSeg);
    end

    // Drop enable during digit 2 SHOW, accept a word while dark, re-enable.
    waitFrameDone("disable");
    tick(20);
    checkOutput("d2ShowAn", 32'(an), 32'hB);
    enable = 1'b0;
    tick(1);
    checkOutput("disableAn", 32'(an), 32'hF);
    checkOutput("disableSeg", 32'(segOut), 32'h0);
    applyStimulus(16'h0007, 4'b0000);
    checkOutput("acceptWhileIdle", 32'(inReady), 32'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (frameDone) pulses++;
    end
    checkOutput("noFrameDoneIdle", 32'(pulses), 32'd0);
    enable = 1'b1;
    tick(1);
    checkOutput("reenableAn", 32'(an), 32'hF);
    checkOutput("transferOnEnable", 32'(inReady), 32'd1);
    tick(2);
`ifdef SEG_SCAN_LZB_EN
    checkFrame("reenable", 32'h000000E0);
`else
    checkFrame("reenable", 32'hFCFCFCE0);
`endif

    // Reset mid-frame with a word pending.
    applyStimulus(16'h8888, 4'b1111);
    rst = 1'b1;
    tick(1);
    checkOutput("midRstAn", 32'(an), 32'hF);
    checkOutput("midRstSeg", 32'(segOut), 32'h0);
    checkOutput("midRstReady", 32'(inReady), 32'd1);
    checkOutput("midRstFrameDone", 32'(frameDone), 32'd0);
    rst = 1'b0;
    tick(3);
`ifdef SEG_SCAN_LZB_EN
    checkFrame("afterRst", 32'h000000FC);
    waitFrameDone("afterRst2");
    tick(3);
    checkFrame("pendDiscarded", 32'h000000FC);
`else
    checkFrame("afterRst", 32'hFCFCFCFC);
    waitFrameDone("afterRst2");
    tick(3);
    checkFrame("pendDiscarded", 32'hFCFCFCFC);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule
